// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first serial out.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_active,
  output logic             word_done
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic             ser_bit_n, active_n, done_n;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             parity, parity_n;
`endif

  // Ready is decoded from state alone so upstream never sees a combinational path back.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:   in_ready = 1'b1;
`ifdef SER_PARITY_EN
      S_SHIFT:  in_ready = 1'b0;
      S_PARITY: in_ready = 1'b1;
`else
      S_SHIFT:  in_ready = (count == LAST);
`endif
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Next-state: default is to fall back to idle; shifting and loading override it.
  always_comb begin
    state_n   = S_IDLE;
    count_n   = '0;
    shift_n   = shift_reg;
    ser_bit_n = IDLE_BIT;
    active_n  = 1'b0;
    done_n    = 1'b0;
`ifdef SER_PARITY_EN
    parity_n  = parity;
`endif
    case (state)
      S_SHIFT: begin
        if (count < LAST) begin
          state_n   = S_SHIFT;
          count_n   = count + CW'(1);
          ser_bit_n = shift_reg[WIDTH-1];
          shift_n   = {shift_reg[WIDTH-2:0], 1'b0};
          active_n  = 1'b1;
`ifdef SER_PARITY_EN
          done_n    = 1'b0;
`else
          done_n    = ((count + CW'(1)) == LAST);
`endif
        end
`ifdef SER_PARITY_EN
        else if (count == LAST) begin
          state_n   = S_PARITY;
          ser_bit_n = parity;
          active_n  = 1'b1;
          done_n    = 1'b1;
        end
`endif
        else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A load only happens where in_ready allows it, so it may override any branch above.
    if (accept) begin
      state_n   = S_SHIFT;
      count_n   = '0;
      ser_bit_n = in_data[WIDTH-1];
      shift_n   = {in_data[WIDTH-2:0], 1'b0};
      active_n  = 1'b1;
      done_n    = 1'b0;
`ifdef SER_PARITY_EN
      parity_n  = ^in_data;
`endif
    end else begin
      state_n = state_n;
    end
  end

  // State and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      shift_reg  <= '0;
      ser_bit    <= IDLE_BIT;
      ser_active <= 1'b0;
      word_done  <= 1'b0;
`ifdef SER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      shift_reg  <= shift_n;
      ser_bit    <= ser_bit_n;
      ser_active <= active_n;
      word_done  <= done_n;
`ifdef SER_PARITY_EN
      parity     <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: expected {bit, done} pairs queued at accept, popped per active cycle.
module tb_bit_serializer;
  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, ser_bit, ser_active, word_done;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_bit(ser_bit), .ser_active(ser_active), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SER_PARITY_EN
      exp_q.push_back({d[i], 1'b0});
`else
      exp_q.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
`endif
    end
`ifdef SER_PARITY_EN
    exp_q.push_back({^d, 1'b1});
`endif
  endtask

  task automatic monitor();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (ser_active) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor_extra: ser_active=1 ser_bit=%b with no bit expected", ser_bit);
          end else begin
            e = exp_q.pop_front();
            if ({ser_bit, word_done} !== e) begin
              errors++;
              $display("FAIL monitor_bit: bit/done=%b/%b expected %b/%b at %0t",
                       ser_bit, word_done, e[1], e[0], $time);
            end
          end
        end else if (ser_bit !== 1'b1 || word_done !== 1'b0) begin
          errors++;
          $display("FAIL monitor_idle: ser_bit=%b word_done=%b expected 1/0", ser_bit, word_done);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller #1 after the accept edge, i.e. in the cycle carrying the MSB.
  task automatic send(input logic [WIDTH-1:0] d);
    int k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    checks++;
    if (k >= 64) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 64 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      push_word(d);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || ser_active) && k < 100) begin
      step();
      k++;
    end
    step();
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL drain_timeout: queue=%0d ser_active=%b expected empty/0", exp_q.size(), ser_active);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({ser_bit, ser_active, word_done, in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL %s: bit/active/done/ready=%b%b%b%b expected 1001", tag, ser_bit, ser_active, word_done, in_ready);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    step();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    step();
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] got = '0;
    int dones = 0;
    send(8'h36);
    for (int c = 0; c < WIDTH; c++) begin
      got = {got[WIDTH-2:0], ser_bit};
      if (word_done) dones++;
      step();
    end
    checks++;
    if (got !== 8'h36) begin
      errors++;
      $display("FAIL single_stream: got %h expected 36", got);
    end
`ifndef SER_PARITY_EN
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d expected 1", dones);
    end
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    send(8'hA5);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    for (int c = 0; c < NB; c++) begin
      checks++;
      if (ser_active !== 1'b1 || in_ready !== (c == NB - 1)) begin
        errors++;
        $display("FAIL b2b_first c=%0d: active/ready=%b/%b expected 1/%b", c, ser_active, in_ready, c == NB - 1);
      end
      if (c == NB - 1) push_word(8'h3C);
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < NB; c++) begin
      checks++;
      if (ser_active !== 1'b1 || in_ready !== (c == NB - 1)) begin
        errors++;
        $display("FAIL b2b_second c=%0d: active/ready=%b/%b expected 1/%b", c, ser_active, in_ready, c == NB - 1);
      end
      step();
    end
    drain();
  endtask

  task automatic test_stall();
    send(8'hC3);
    in_valid = 1'b1;
    for (int c = 0; c < WIDTH - 2; c++) begin
      in_data = WIDTH'($urandom);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready c=%0d: got %b expected 0", c, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    send(8'hFF);
    step();
    step();
    step();
    #1 rst = 1'b1;
    exp_q.delete();
    #1 check_reset_outputs("reset_mid");
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset_mid_idle");
    send(8'h00);
    drain();
  endtask

  task automatic test_parity();
    send(8'h07);
    for (int c = 0; c < NB - 1; c++) step();
    checks++;
    if (in_ready !== 1'b1 || word_done !== 1'b1 || ser_active !== 1'b1) begin
      errors++;
      $display("FAIL final_cycle: ready/done/active=%b%b%b expected 111", in_ready, word_done, ser_active);
    end
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_parity();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected bits never emitted, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
